// File: rtl/param_fifo_ifc.sv
// -----------------------------------------------------------------------------
// param_fifo_ifc
//
// Register-mapped two-input / one-output FIFO block. Operands are written into
// FIFO A and FIFO B through an addressed write port; a compute stage pops one
// operand from each whenever it can and pushes op(a,b) into FIFO Y. Results and
// status are fetched through an addressed, combinational read port.
//
// Optional build macro:
//   PARAM_FIFO_IFC_ERR_FLAGS_EN - adds the sticky error-flag register read at
//                                 address 7 (bit0 A overflow, bit1 B overflow,
//                                 bit2 Y underflow, cleared by reading it).
//                                 Without it address 7 reads 0.
//
// Ports:
//   CLK            rising-edge clock
//   RST_N          asynchronous active-low reset
//   write_address  write target (4: push A, 5: push B, 6: OP)
//   write_data     write payload
//   write_en       write strobe, honoured only while write_rdy=1
//   write_rdy      write port ready
//   read_address   read source (0..7 status/data map)
//   read_en        read strobe, honoured only while read_rdy=1
//   read_data      read result, combinational from read_address
//   read_rdy       read port ready
// -----------------------------------------------------------------------------
module param_fifo_ifc #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    output logic              write_rdy,
    input  logic [ADDR_W-1:0] read_address,
    input  logic              read_en,
    output logic [DATA_W-1:0] read_data,
    output logic              read_rdy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [ADDR_W-1:0] ADDR_A_NFULL = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_B_NFULL = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_Y_NEMPT = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_Y_DATA  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_A       = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_B       = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] ADDR_OP      = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] ADDR_ERR     = ADDR_W'(7);

    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_XOR = 2'd2,
        OP_ADD = 2'd3
    } op_e;

    logic              rdy_q, rdy_d;
    op_e               op_q, op_d;

    logic [DATA_W-1:0] mem_a_q [DEPTH];
    logic [DATA_W-1:0] mem_a_d [DEPTH];
    logic [DATA_W-1:0] mem_b_q [DEPTH];
    logic [DATA_W-1:0] mem_b_d [DEPTH];
    logic [DATA_W-1:0] mem_y_q [DEPTH];
    logic [DATA_W-1:0] mem_y_d [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_a_q, wr_ptr_a_d, rd_ptr_a_q, rd_ptr_a_d;
    logic [PTR_W-1:0]  wr_ptr_b_q, wr_ptr_b_d, rd_ptr_b_q, rd_ptr_b_d;
    logic [PTR_W-1:0]  wr_ptr_y_q, wr_ptr_y_d, rd_ptr_y_q, rd_ptr_y_d;
    logic [CNT_W-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cnt_y_q, cnt_y_d;

    logic              a_full, b_full, y_full, a_empty, b_empty, y_empty;
    logic              wr_fire, rd_fire;
    logic              push_a_req, push_b_req, pop_y_req;
    logic              push_a, push_b, pop_y, fire;
    logic              err_clr;
    logic [DATA_W-1:0] op_a, op_b, result;
    logic [DATA_W-1:0] err_rd;
    logic [DATA_W-1:0] rd_mux;

    // Both ports come up together one edge after reset release.
    assign write_rdy = rdy_q;
    assign read_rdy  = rdy_q;
    assign rdy_d     = 1'b1;

    // All FIFO status is taken from start-of-cycle state, so pushes never
    // bypass a same-cycle pop and a same-cycle Y pop never unblocks compute.
    assign a_full  = (cnt_a_q == FULL_CNT);
    assign b_full  = (cnt_b_q == FULL_CNT);
    assign y_full  = (cnt_y_q == FULL_CNT);
    assign a_empty = (cnt_a_q == '0);
    assign b_empty = (cnt_b_q == '0);
    assign y_empty = (cnt_y_q == '0);

    assign wr_fire    = write_en & rdy_q;
    assign rd_fire    = read_en & rdy_q;
    assign push_a_req = wr_fire && (write_address == ADDR_A);
    assign push_b_req = wr_fire && (write_address == ADDR_B);
    assign pop_y_req  = rd_fire && (read_address == ADDR_Y_DATA);
    assign err_clr    = rd_fire && (read_address == ADDR_ERR);
    assign push_a     = push_a_req && !a_full;
    assign push_b     = push_b_req && !b_full;
    assign pop_y      = pop_y_req && !y_empty;
    assign fire       = !a_empty && !b_empty && !y_full;

    assign op_a = mem_a_q[rd_ptr_a_q];
    assign op_b = mem_b_q[rd_ptr_b_q];

    // Compute always uses the registered OP, so an OP write only affects
    // computes from the following cycle on.
    always_comb begin
        result = op_a | op_b;
        case (op_q)
            OP_OR:   result = op_a | op_b;
            OP_AND:  result = op_a & op_b;
            OP_XOR:  result = op_a ^ op_b;
            OP_ADD:  result = op_a + op_b;
            default: result = op_a | op_b;
        endcase
    end

    // Next-state for the three FIFOs and the OP register.
    always_comb begin
        mem_a_d    = mem_a_q;
        mem_b_d    = mem_b_q;
        mem_y_d    = mem_y_q;
        wr_ptr_a_d = wr_ptr_a_q;
        rd_ptr_a_d = rd_ptr_a_q;
        wr_ptr_b_d = wr_ptr_b_q;
        rd_ptr_b_d = rd_ptr_b_q;
        wr_ptr_y_d = wr_ptr_y_q;
        rd_ptr_y_d = rd_ptr_y_q;
        op_d       = op_q;

        if (push_a) begin
            mem_a_d[wr_ptr_a_q] = write_data;
            wr_ptr_a_d          = wr_ptr_a_q + PTR_W'(1);
        end
        if (push_b) begin
            mem_b_d[wr_ptr_b_q] = write_data;
            wr_ptr_b_d          = wr_ptr_b_q + PTR_W'(1);
        end
        if (fire) begin
            rd_ptr_a_d          = rd_ptr_a_q + PTR_W'(1);
            rd_ptr_b_d          = rd_ptr_b_q + PTR_W'(1);
            mem_y_d[wr_ptr_y_q] = result;
            wr_ptr_y_d          = wr_ptr_y_q + PTR_W'(1);
        end
        if (pop_y) begin
            rd_ptr_y_d = rd_ptr_y_q + PTR_W'(1);
        end
        if (wr_fire && (write_address == ADDR_OP)) begin
            op_d = op_e'(2'(write_data));
        end

        cnt_a_d = cnt_a_q + CNT_W'(push_a) - CNT_W'(fire);
        cnt_b_d = cnt_b_q + CNT_W'(push_b) - CNT_W'(fire);
        cnt_y_d = cnt_y_q + CNT_W'(fire) - CNT_W'(pop_y);
    end

    // Control state: pointers, counts, OP and port readiness.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdy_q      <= 1'b0;
            op_q       <= OP_OR;
            wr_ptr_a_q <= '0;
            rd_ptr_a_q <= '0;
            wr_ptr_b_q <= '0;
            rd_ptr_b_q <= '0;
            wr_ptr_y_q <= '0;
            rd_ptr_y_q <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            cnt_y_q    <= '0;
        end else begin
            rdy_q      <= rdy_d;
            op_q       <= op_d;
            wr_ptr_a_q <= wr_ptr_a_d;
            rd_ptr_a_q <= rd_ptr_a_d;
            wr_ptr_b_q <= wr_ptr_b_d;
            rd_ptr_b_q <= rd_ptr_b_d;
            wr_ptr_y_q <= wr_ptr_y_d;
            rd_ptr_y_q <= rd_ptr_y_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            cnt_y_q    <= cnt_y_d;
        end
    end

    // Storage needs no reset: emptiness is tracked entirely by the counts,
    // and nothing is written while the ports are not ready.
    always_ff @(posedge CLK) begin
        mem_a_q <= mem_a_d;
        mem_b_q <= mem_b_d;
        mem_y_q <= mem_y_d;
    end

`ifdef PARAM_FIFO_IFC_ERR_FLAGS_EN
    logic [2:0] err_q, err_d;
    logic [2:0] err_set;

    // Sticky flags; a set in the same cycle as a clearing read wins.
    assign err_set = {pop_y_req && y_empty, push_b_req && b_full, push_a_req && a_full};

    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end
        err_d = err_d | err_set;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_rd = DATA_W'(err_q);
`else
    assign err_rd = '0;
`endif

    // Read mux; narrow fields are zero-extended, and everything reads 0
    // until the port is ready.
    always_comb begin
        rd_mux = '0;
        case (read_address)
            ADDR_A_NFULL: rd_mux = DATA_W'(!a_full);
            ADDR_B_NFULL: rd_mux = DATA_W'(!b_full);
            ADDR_Y_NEMPT: rd_mux = DATA_W'(!y_empty);
            ADDR_Y_DATA:  rd_mux = y_empty ? '0 : mem_y_q[rd_ptr_y_q];
            ADDR_A:       rd_mux = DATA_W'(cnt_a_q);
            ADDR_B:       rd_mux = DATA_W'(cnt_b_q);
            ADDR_OP:      rd_mux = DATA_W'(op_q);
            ADDR_ERR:     rd_mux = err_rd;
            default:      rd_mux = '0;
        endcase
        read_data = rdy_q ? rd_mux : '0;
    end

endmodule

// File: tb/tb_param_fifo_ifc.sv
// -----------------------------------------------------------------------------
// tb_param_fifo_ifc
//
// Self-checking bench for param_fifo_ifc (DATA_W=8, DEPTH=4). A queue-based
// reference model tracks the three FIFOs, OP and error flags; every read is
// compared against it, and the directed scenarios add fixed expected values.
// -----------------------------------------------------------------------------
module tb_param_fifo_ifc;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 3;

    logic              CLK;
    logic              RST_N;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;
    logic              write_en;
    logic              write_rdy;
    logic [ADDR_W-1:0] read_address;
    logic              read_en;
    logic [DATA_W-1:0] read_data;
    logic              read_rdy;

    int errCount   = 0;
    int checkCount = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qy[$];
    int         mOp;
    logic [2:0] mErr;
    logic [7:0] lastRead;

    param_fifo_ifc #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .write_address(write_address),
        .write_data   (write_data),
        .write_en     (write_en),
        .write_rdy    (write_rdy),
        .read_address (read_address),
        .read_en      (read_en),
        .read_data    (read_data),
        .read_rdy     (read_rdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [7:0] modelOp(input int op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            0:       return a | b;
            1:       return a & b;
            2:       return a ^ b;
            default: return 8'((int'(a) + int'(b)) % 256);
        endcase
    endfunction

    // Expected read value from the model's start-of-cycle state.
    function automatic logic [7:0] modelRead(input int ra);
        case (ra)
            0: return (qa.size() < DEPTH) ? 8'd1 : 8'd0;
            1: return (qb.size() < DEPTH) ? 8'd1 : 8'd0;
            2: return (qy.size() > 0) ? 8'd1 : 8'd0;
            3: return (qy.size() > 0) ? qy[0] : 8'd0;
            4: return 8'(qa.size());
            5: return 8'(qb.size());
            6: return 8'(mOp);
`ifdef PARAM_FIFO_IFC_ERR_FLAGS_EN
            7: return {5'd0, mErr};
`endif
            default: return 8'd0;
        endcase
    endfunction

    // Advance the model by one clock edge using start-of-cycle occupancy.
    task automatic modelStep(input bit we, input int wa, input int wd, input bit re, input int ra);
        bit         canCompute;
        bit         aFull, bFull, yEmpty;
        logic [7:0] a, b, res;
        logic [2:0] setBits;
        canCompute = (qa.size() > 0) && (qb.size() > 0) && (qy.size() < DEPTH);
        aFull      = (qa.size() == DEPTH);
        bFull      = (qb.size() == DEPTH);
        yEmpty     = (qy.size() == 0);
        setBits    = 3'b000;
        res        = 8'd0;
        if (canCompute) begin
            a   = qa.pop_front();
            b   = qb.pop_front();
            res = modelOp(mOp, a, b);
        end
        if (we && wa == 4) begin
            if (aFull) setBits[0] = 1'b1;
            else qa.push_back(8'(wd));
        end
        if (we && wa == 5) begin
            if (bFull) setBits[1] = 1'b1;
            else qb.push_back(8'(wd));
        end
        if (we && wa == 6) mOp = wd % 4;
        if (re && ra == 3) begin
            if (yEmpty) setBits[2] = 1'b1;
            else void'(qy.pop_front());
        end
        if (canCompute) qy.push_back(res);
        if (re && ra == 7) mErr = 3'b000;
        mErr = mErr | setBits;
    endtask

    // One clock cycle of stimulus; checks ready and (if reading) read_data.
    task automatic applyStimulus(input bit we, input int wa, input int wd, input bit re, input int ra);
        write_en      = we;
        write_address = ADDR_W'(wa);
        write_data    = DATA_W'(wd);
        read_en       = re;
        read_address  = ADDR_W'(ra);
        @(negedge CLK);
        checkOutput("write_rdy", 32'(write_rdy), 32'd1);
        lastRead = read_data;
        if (re) begin
            checkOutput($sformatf("read_addr%0d", ra), 32'(read_data), 32'(modelRead(ra)));
        end
        @(posedge CLK);
        modelStep(we, wa, wd, re, ra);
        #1;
    endtask

    task automatic clearModel();
        qa.delete();
        qb.delete();
        qy.delete();
        mOp  = 0;
        mErr = 3'b000;
    endtask

    // Assert reset, check outputs during reset, release between edges and
    // check the ports come ready after the next rising edge.
    task automatic doReset();
        write_en = 1'b0;
        read_en  = 1'b0;
        read_address = ADDR_W'(3);
        RST_N    = 1'b0;
        #1;
        checkOutput("rst_write_rdy", 32'(write_rdy), 32'd0);
        checkOutput("rst_read_rdy", 32'(read_rdy), 32'd0);
        checkOutput("rst_read_data", 32'(read_data), 32'd0);
        clearModel();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("post_rst_write_rdy", 32'(write_rdy), 32'd1);
        checkOutput("post_rst_read_rdy", 32'(read_rdy), 32'd1);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        int wa;
        RST_N         = 1'b0;
        write_en      = 1'b0;
        write_address = '0;
        write_data    = '0;
        read_en       = 1'b0;
        read_address  = '0;
        lastRead      = '0;
        clearModel();
        #12;
        doReset();

        // OR of two operands, result visible two cycles after B lands.
        applyStimulus(1'b1, 4, 'h0F, 1'b0, 0);
        applyStimulus(1'b1, 5, 'hF0, 1'b1, 2);
        checkOutput("or_not_ready_yet", 32'(lastRead), 32'd0);
        idle();
        applyStimulus(1'b0, 0, 0, 1'b1, 2);
        checkOutput("or_y_nonempty", 32'(lastRead), 32'd1);
        applyStimulus(1'b0, 0, 0, 1'b1, 3);
        checkOutput("or_result", 32'(lastRead), 32'hFF);
        applyStimulus(1'b0, 0, 0, 1'b1, 2);
        checkOutput("or_y_empty_after", 32'(lastRead), 32'd0);

        // ADD with wrap.
        applyStimulus(1'b1, 6, 3, 1'b0, 0);
        applyStimulus(1'b1, 4, 'hFF, 1'b0, 0);
        applyStimulus(1'b1, 5, 'h02, 1'b0, 0);
        idle();
        applyStimulus(1'b0, 0, 0, 1'b1, 3);
        checkOutput("add_wrap", 32'(lastRead), 32'h01);
        applyStimulus(1'b0, 0, 0, 1'b1, 6);
        checkOutput("op_readback", 32'(lastRead), 32'd3);

        // Overflow A with B empty.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4, 'h10 + i, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b1, 4);
        checkOutput("a_occupancy_full", 32'(lastRead), 32'd4);
        applyStimulus(1'b0, 0, 0, 1'b1, 0);
        checkOutput("a_not_full_flag", 32'(lastRead), 32'd0);
`ifdef PARAM_FIFO_IFC_ERR_FLAGS_EN
        applyStimulus(1'b0, 0, 0, 1'b1, 7);
        checkOutput("err_a_overflow", 32'(lastRead), 32'd1);
        applyStimulus(1'b0, 0, 0, 1'b1, 7);
        checkOutput("err_cleared", 32'(lastRead), 32'd0);
`else
        applyStimulus(1'b0, 0, 0, 1'b1, 7);
        checkOutput("err_absent", 32'(lastRead), 32'd0);
`endif

        // Six pairs without draining Y: Y fills, A/B keep two each.
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 4, 'h20 + i, 1'b0, 0);
            applyStimulus(1'b1, 5, 'h41 + i, 1'b0, 0);
        end
        idle();
        applyStimulus(1'b0, 0, 0, 1'b1, 4);
        checkOutput("backpressure_a_occ", 32'(lastRead), 32'd2);
        applyStimulus(1'b0, 0, 0, 1'b1, 5);
        checkOutput("backpressure_b_occ", 32'(lastRead), 32'd2);
        applyStimulus(1'b0, 0, 0, 1'b1, 3);
        checkOutput("backpressure_y_head", 32'(lastRead), 32'h61);
        applyStimulus(1'b0, 0, 0, 1'b1, 4);
        checkOutput("one_more_pre_edge", 32'(lastRead), 32'd2);
        applyStimulus(1'b0, 0, 0, 1'b1, 4);
        checkOutput("one_more_fired", 32'(lastRead), 32'd1);
        applyStimulus(1'b0, 0, 0, 1'b1, 4);
        checkOutput("only_one_more", 32'(lastRead), 32'd1);

        // Empty Y read.
        doReset();
        applyStimulus(1'b0, 0, 0, 1'b1, 3);
        checkOutput("y_empty_read", 32'(lastRead), 32'd0);
        applyStimulus(1'b0, 0, 0, 1'b1, 2);
        checkOutput("y_still_empty", 32'(lastRead), 32'd0);
`ifdef PARAM_FIFO_IFC_ERR_FLAGS_EN
        applyStimulus(1'b0, 0, 0, 1'b1, 7);
        checkOutput("err_y_underflow", 32'(lastRead), 32'd4);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4) wa = 4;
            else if (r < 8) wa = 5;
            else if (r == 8) wa = 6;
            else wa = int'($urandom_range(0, 7));
            applyStimulus($urandom_range(0, 3) != 0, wa, int'($urandom_range(0, 255)),
                          $urandom_range(0, 2) != 0,
                          ($urandom_range(0, 1) != 0) ? 3 : int'($urandom_range(0, 7)));
        end

        // Reset in the middle of a compute with all FIFOs holding data.
        applyStimulus(1'b1, 6, 0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4, 'h31 + i, 1'b0, 0);
            applyStimulus(1'b1, 5, 'h52 + i, 1'b0, 0);
        end
        read_en      = 1'b0;
        read_address = ADDR_W'(3);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("midrst_read_data", 32'(read_data), 32'd0);
        checkOutput("midrst_write_rdy", 32'(write_rdy), 32'd0);
        checkOutput("midrst_read_rdy", 32'(read_rdy), 32'd0);
        clearModel();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        applyStimulus(1'b0, 0, 0, 1'b1, 4);
        checkOutput("midrst_a_occ", 32'(lastRead), 32'd0);
        applyStimulus(1'b0, 0, 0, 1'b1, 5);
        checkOutput("midrst_b_occ", 32'(lastRead), 32'd0);
        applyStimulus(1'b0, 0, 0, 1'b1, 2);
        checkOutput("midrst_y_empty", 32'(lastRead), 32'd0);
        applyStimulus(1'b0, 0, 0, 1'b1, 6);
        checkOutput("midrst_op", 32'(lastRead), 32'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/param_fifo_ifc.md
Name: param_fifo_ifc

Overview:
- Parametrised successor of the team's register-mapped two-input/one-output FIFO interface block.
- Operands are written into FIFO A and FIFO B through an addressed write port. A compute stage pops one operand from each and pushes op(a,b) into FIFO Y.
- Results and status are fetched through an addressed read port.
- Adds configurable data width and depth, a runtime-selectable operation, and an optional error-flag register.

Parameters:
DATA_W, 8, operand/result width in bits (1..32)
DEPTH, 4, entries per FIFO; power of two, 2..64
ADDR_W, 3, address width; fixed map uses addresses 0..7

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
write_address  input  ADDR_W  write target
write_data  input  DATA_W  write payload
write_en  input  1  write strobe; honoured only when write_rdy=1
write_rdy  output  1  write port ready
read_address  input  ADDR_W  read source
read_en  input  1  read strobe; honoured only when read_rdy=1
read_data  output  DATA_W  read result, combinational from read_address
read_rdy  output  1  read port ready

Behaviour:
- Reset (async assert, sync release):
  - All FIFOs empty; OP=0; error flags clear.
  - write_rdy=0, read_rdy=0, read_data=0 while RST_N=0.
  - write_rdy=read_rdy=1 from the first CLK edge after release.
- Reset mid-operation discards all FIFO contents and any in-flight compute; no partial push survives.
- Write map (effect at CLK edge when write_en&write_rdy):
  - 4: push write_data into A.
  - 5: push write_data into B.
  - 6: OP <= write_data[1:0].
  - Any other address: ignored, no side effect.
- Read map (read_data valid in the same cycle as read_en; side effects at the edge):
  - 0: A not full (bit0).
  - 1: B not full (bit0).
  - 2: Y not empty (bit0).
  - 3: Y head data; pops Y.
  - 4: A occupancy.
  - 5: B occupancy.
  - 6: OP (zero-extended).
  - 7: error register (see Optional Feature).
- Narrow status fields are zero-extended to DATA_W.
- Push to a full A/B: data dropped, FIFO unchanged.
- Read of address 3 with Y empty: returns 0, no pop.
- Fullness is evaluated at the start of the cycle. A push to a full FIFO is rejected even if the compute stage pops it in the same cycle (no bypass).
- Compute fires each cycle where A non-empty, B non-empty and Y not full (start-of-cycle state):
  - Pops A and B, pushes op(a,b) into Y.
  - Throughput one per cycle. Result readable at address 3 one cycle after the operands are both present.
- Y full blocks compute even if Y is popped by a read in the same cycle.
- OP encoding:
  - 0 = OR, 1 = AND, 2 = XOR.
  - 3 = ADD modulo 2^DATA_W; carry discarded.
- An OP write takes effect for computes from the next cycle; a same-cycle compute uses the old OP.
- Simultaneous write and read in one cycle are both honoured. A read of A/B occupancy in that cycle returns the pre-edge value.
- Pointers wrap modulo DEPTH. Occupancy is a log2(DEPTH)+1-bit counter, saturating only by the full/empty rules.

Optional Feature:
Macro: PARAM_FIFO_IFC_ERR_FLAGS_EN
- Defined: address 7 read returns {.., y_underflow, b_overflow, a_overflow} in bits [2:0].
  - Flags are sticky; set by a dropped push (A/B) or an empty Y read.
  - Cleared on read of address 7. A set and clear in the same cycle leaves the flag set.
- Undefined: address 7 reads 0; no flag logic is synthesised.

Test Plan:
- Reset, then write 4:0x0F, 5:0xF0 (OP=OR) -> read 2 returns 1 two cycles later; read 3 returns 0xFF; then read 2 returns 0.
- Write 6:3, then A=0xFF, B=0x02 -> read 3 returns 0x01 (ADD wrap); read 6 returns 3.
- Push 5 values to A with B empty (DEPTH=4) -> read 4 returns 4, read 0 returns 0. Fifth value lost; with the macro defined, read 7 returns 0x1, then 0x0 on the next read.
- Fill A and B with 6 pairs without reading Y -> Y holds 4 results, A/B occupancy 2 each. Reading Y once lets exactly one more compute fire a cycle later.
- Read 3 with Y empty -> read_data=0, no state change; macro defined -> read 7 returns 0x4.
- Assert RST_N=0 mid-compute with data in all FIFOs -> outputs 0 immediately. After release, all occupancies 0, read 2 returns 0, OP=0.
